// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD count chain: command opcodes, controller
// states and the BCD digit ceiling.
package bcd_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_START = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-decimal limit nibbles could never be matched, so pin them to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the count chain: counts 0..9 when enabled and emits a
// combinational carry when it rolls over from 9.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       load_zero,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
        end else if (clr || load_zero) begin
            r_digit <= 4'd0;
        end else if (en) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = en && (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Multi-digit BCD counter controller: command handshake, prescaler, FSM,
// terminal detection. Optional lap capture enabled by BCD_LAP_CAPTURE_EN.
module bcd_count_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*DIGITS-1:0] limit,
    input  logic                auto_wrap,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                tc_pulse,
    input  logic                lap_req,
    output logic [4*DIGITS-1:0] lap_value,
    output logic                lap_valid
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_e        r_state, w_state_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic [W-1:0]  r_limit;
    logic [W-1:0]  w_limit_clamped;
    logic [W-1:0]  w_count;
    logic          r_wrap, r_busy, r_tc;
    logic          w_accept, w_start, w_stop, w_clear;
    logic          w_tick, w_at_term, w_inc, w_load_zero;
    logic [DIGITS:0] w_carry;
    logic          w_unused_carry;

    assign cmd_ready = !r_busy;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_start   = w_accept && (cmd_op == CMD_START);
    assign w_stop    = w_accept && (cmd_op == CMD_STOP);
    assign w_clear   = w_accept && (cmd_op == CMD_CLEAR);

    assign w_tick    = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
    assign w_at_term = (w_count == r_limit);
    // CLEAR outranks a coincident tick: no increment, no wrap, no pulse.
    assign w_inc       = w_tick && !w_clear && !w_at_term;
    assign w_load_zero = (w_tick && !w_clear && w_at_term && r_wrap)
                       || (w_start && (r_state == ST_HOLD));

    assign w_carry[0]     = w_inc;
    assign w_unused_carry = w_carry[DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_limit_clamped[4*gi +: 4] = bcd_clamp(limit[4*gi +: 4]);

            bcd_digit_cell u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (w_carry[gi]),
                .clr       (w_clear),
                .load_zero (w_load_zero),
                .digit     (w_count[4*gi +: 4]),
                .carry     (w_carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_RUN;
                    w_presc_next = '0;
                end
            end
            ST_RUN: begin
                w_presc_next = w_tick ? '0 : r_presc + 1'b1;
                if (w_clear) begin
                    w_presc_next = '0;
                end else if (w_stop) begin
                    w_state_next = ST_IDLE;
                    if (!w_tick) w_presc_next = r_presc;
                end else if (w_tick && w_at_term && !r_wrap) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_start) begin
                    w_state_next = ST_RUN;
                    w_presc_next = '0;
                end else if (w_clear || w_stop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_limit <= '0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_busy  <= w_accept;
            r_tc    <= w_tick && !w_clear && w_at_term;
            if (w_start && (r_state != ST_RUN)) begin
                r_limit <= w_limit_clamped;
                r_wrap  <= auto_wrap;
            end
        end
    end

    assign count    = w_count;
    assign running  = (r_state == ST_RUN);
    assign tc_pulse = r_tc;

`ifdef BCD_LAP_CAPTURE_EN
    logic         r_lap_req_d;
    logic [W-1:0] r_lap_value;
    logic         r_lap_valid;

    // Registered count is still pre-increment on a tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_req_d <= 1'b0;
            r_lap_value <= '0;
            r_lap_valid <= 1'b0;
        end else begin
            r_lap_req_d <= lap_req;
            if (w_clear) begin
                r_lap_valid <= 1'b0;
            end else if (lap_req && !r_lap_req_d) begin
                r_lap_value <= w_count;
                r_lap_valid <= 1'b1;
            end
        end
    end

    assign lap_value = r_lap_value;
    assign lap_valid = r_lap_valid;
`else
    logic w_unused_lap_req;
    assign w_unused_lap_req = lap_req;
    assign lap_value        = '0;
    assign lap_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl (DIGITS=4, PRESCALE=3); lap checks follow
// BCD_LAP_CAPTURE_EN.
module tb_bcd_count_ctrl;
    import bcd_pkg::*;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 3;
    localparam int W        = 4 * DIGITS;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op    = 2'b00;
    logic [W-1:0] limit     = '0;
    logic         auto_wrap = 1'b0;
    logic         lap_req   = 1'b0;
    logic         cmd_ready, running, tc_pulse, lap_valid;
    logic [W-1:0] count, lap_value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           k;
        logic [W-1:0] cnt;
        logic         tc;
        logic         run;
        logic         rdy;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    bcd_count_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .limit     (limit),
        .auto_wrap (auto_wrap),
        .count     (count),
        .running   (running),
        .tc_pulse  (tc_pulse),
        .lap_req   (lap_req),
        .lap_value (lap_value),
        .lap_valid (lap_valid)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic issue(input logic [1:0] op);
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = CMD_NOP;
    endtask

    task automatic wait_count(input logic [W-1:0] target, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step(1);
            if (count == target) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_count actual=%h required=%h", count, target);
        end else begin
            $display("ok   reached count %h", target);
        end
    endtask

    initial begin
        int kn;
        // Wrap run, limit 5, PRESCALE 3: k = clk edges after START accept.
        vecs = '{
            '{0,  16'h0000, 1'b0, 1'b1, 1'b0},
            '{2,  16'h0000, 1'b0, 1'b1, 1'b1},
            '{3,  16'h0001, 1'b0, 1'b1, 1'b1},
            '{6,  16'h0002, 1'b0, 1'b1, 1'b1},
            '{15, 16'h0005, 1'b0, 1'b1, 1'b1},
            '{17, 16'h0005, 1'b0, 1'b1, 1'b1},
            '{18, 16'h0000, 1'b1, 1'b1, 1'b1},
            '{19, 16'h0000, 1'b0, 1'b1, 1'b1},
            '{21, 16'h0001, 1'b0, 1'b1, 1'b1},
            '{35, 16'h0005, 1'b0, 1'b1, 1'b1},
            '{36, 16'h0000, 1'b1, 1'b1, 1'b1},
            '{37, 16'h0000, 1'b0, 1'b1, 1'b1}
        };

        #3;
        chk("rst count", count, 16'h0000);
        chk("rst running", running, 1'b0);
        chk("rst ready", cmd_ready, 1'b1);
        chk("rst tc", tc_pulse, 1'b0);
        chk("rst lap_value", lap_value, 16'h0000);
        chk("rst lap_valid", lap_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        limit     = 16'h0005;
        auto_wrap = 1'b1;
        issue(CMD_START);
        kn = 0;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].k - kn);
            kn = vecs[i].k;
            $display("vec %0d k=%0d", i, kn);
            chk("wrap count", count, vecs[i].cnt);
            chk("wrap tc", tc_pulse, vecs[i].tc);
            chk("wrap running", running, vecs[i].run);
            chk("wrap ready", cmd_ready, vecs[i].rdy);
        end

        // Back-to-back: STOP then CLEAR held valid; CLEAR lands 2 cycles later.
        step(45 - kn);
        cmd_op    = CMD_STOP;
        cmd_valid = 1'b1;
        step(1);
        chk("b2b ready low", cmd_ready, 1'b0);
        chk("b2b stopped", running, 1'b0);
        chk("b2b count frozen", count, 16'h0003);
        cmd_op = CMD_CLEAR;
        step(1);
        chk("b2b clear pending", count, 16'h0003);
        chk("b2b ready back", cmd_ready, 1'b1);
        step(1);
        cmd_valid = 1'b0;
        cmd_op    = CMD_NOP;
        chk("b2b cleared", count, 16'h0000);
        chk("b2b ready low2", cmd_ready, 1'b0);

        // CLEAR on the terminal tick at 9, then STOP on a tick at 4.
        limit = 16'h0009;
        step(1);
        issue(CMD_START);
        step(29);
        chk("coll pre count", count, 16'h0009);
        issue(CMD_CLEAR);
        chk("coll clear count", count, 16'h0000);
        chk("coll clear tc", tc_pulse, 1'b0);
        chk("coll clear running", running, 1'b1);
        step(14);
        chk("coll pre stop", count, 16'h0004);
        issue(CMD_STOP);
        chk("coll stop count", count, 16'h0005);
        chk("coll stop running", running, 1'b0);
        step(1);
        chk("idle frozen", count, 16'h0005);
        issue(CMD_CLEAR);
        chk("idle clear", count, 16'h0000);

        // Hold at limit 0x12, then restart with a clamped limit (0x0C -> 0x09).
        limit     = 16'h0012;
        auto_wrap = 1'b0;
        step(1);
        issue(CMD_START);
        step(38);
        chk("hold pre count", count, 16'h0012);
        chk("hold pre running", running, 1'b1);
        step(1);
        chk("hold count", count, 16'h0012);
        chk("hold running", running, 1'b0);
        chk("hold tc", tc_pulse, 1'b1);
        step(4);
        chk("hold stays", count, 16'h0012);
        chk("hold tc gone", tc_pulse, 1'b0);
        issue(CMD_NOP);
        chk("nop count", count, 16'h0012);
        chk("nop ready", cmd_ready, 1'b0);
        step(1);
        limit = 16'h000C;
        issue(CMD_START);
        chk("restart count", count, 16'h0000);
        chk("restart running", running, 1'b1);
        limit = 16'h0003;
        step(30);
        chk("clamp hold count", count, 16'h0009);
        chk("clamp hold running", running, 1'b0);
        chk("clamp hold tc", tc_pulse, 1'b1);
        step(1);
        issue(CMD_CLEAR);
        chk("hold clear count", count, 16'h0000);
        chk("hold clear running", running, 1'b0);

        // Long run: lap capture, digit ripple, full-scale wrap.
        limit     = 16'h9999;
        auto_wrap = 1'b1;
        step(1);
        issue(CMD_START);
        wait_count(16'h0042, 400);
        lap_req = 1'b1;
        step(1);
        lap_req = 1'b0;
`ifdef BCD_LAP_CAPTURE_EN
        chk("lap value", lap_value, 16'h0042);
        chk("lap valid", lap_valid, 1'b1);
`else
        chk("lap value off", lap_value, 16'h0000);
        chk("lap valid off", lap_valid, 1'b0);
`endif
        chk("lap running", running, 1'b1);
        wait_count(16'h0098, 400);
        step(3);
        chk("ripple 99", count, 16'h0099);
        step(3);
        chk("ripple 100", count, 16'h0100);
        wait_count(16'h9999, 40000);
        step(3);
        chk("full wrap count", count, 16'h0000);
        chk("full wrap tc", tc_pulse, 1'b1);

        // Asynchronous reset in the middle of a cycle.
        wait_count(16'h0347, 2000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst count", count, 16'h0000);
        chk("async rst running", running, 1'b0);
        chk("async rst ready", cmd_ready, 1'b1);
        chk("async rst tc", tc_pulse, 1'b0);
        chk("async rst lap_valid", lap_valid, 1'b0);
        #20;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Controller and sequencer for a multi-digit BCD count chain built from single-digit BCD cells.
- Accepts start/stop/clear commands over a valid/ready handshake.
- Divides the clock into count ticks with a prescaler.
- Ripples carries between digits.
- Detects a programmable terminal value, then either wraps or holds.
- Feeds display/timer logic with a stable packed BCD count.

Parameters:
DIGITS, 4, number of BCD digits in the chain (1..8)
PRESCALE, 10, clk cycles per count tick (>=1; 1 = tick every cycle)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 CLEAR
limit  input  4*DIGITS  terminal value, packed BCD, digit 0 in [3:0]
auto_wrap  input  1  1 = wrap to 0 at terminal; 0 = hold at terminal
count  output  4*DIGITS  packed BCD count
running  output  1  high in RUN state
tc_pulse  output  1  one-cycle pulse on the tick that reaches terminal
lap_req  input  1  lap capture strobe (used only with the optional feature)
lap_value  output  4*DIGITS  captured count
lap_valid  output  1  lap_value holds a capture

Behaviour:
Reset (async assert, sync release):
- count=0, prescaler=0, latched limit=0, state=IDLE.
- running=0, tc_pulse=0, cmd_ready=1, lap_value=0, lap_valid=0.

Handshake:
- A command is accepted when cmd_valid && cmd_ready.
- cmd_ready drops for exactly one cycle after each accept, then returns to 1.
- A NOP is accepted but has no effect.

States:
- IDLE: count frozen.
  - START: latch limit and auto_wrap, prescaler:=0, go to RUN.
  - CLEAR: count:=0.
- RUN: prescaler increments every cycle; tick when prescaler==PRESCALE-1, then prescaler:=0.
  - STOP: go to IDLE; prescaler holds its value, so a later START restarts the prescaler from 0.
  - CLEAR: count:=0 and prescaler:=0; state stays RUN.
- HOLD: entered on a terminal tick when auto_wrap=0. count frozen at the limit.
  - START: count:=0, go to RUN.
  - CLEAR: count:=0, go to IDLE.
  - STOP: go to IDLE.

Count arithmetic (on a tick):
- Digit i increments when all lower digits ==9.
- A digit at 9 wraps to 0 and carries to the next digit.
- All-9s wraps to all-0s; the carry out of the top digit is discarded.

Terminal detection:
- Evaluated on a tick when count==latched limit (before increment). tc_pulse=1 on the following cycle.
- auto_wrap=1: count:=0 instead of incrementing; state stays RUN.
- auto_wrap=0: count unchanged; go to HOLD.

Limit handling:
- Limit nibbles >9 are clamped to 9 when latched.
- limit changes after START are ignored until the next START.

Simultaneous events:
- CLEAR coinciding with a tick: CLEAR wins; no increment and no tc_pulse.
- STOP coinciding with a tick: the tick is applied first, then the state goes to IDLE.

Other:
- Latency: count updates on the clock edge after the tick cycle.
- Reset asserted mid-run: immediate return to reset values.

Optional Feature:
BCD_LAP_CAPTURE_EN
- Defined: a lap_req rising edge (detected internally) copies count into lap_value and sets lap_valid. lap_valid clears on CLEAR.
  - If lap_req coincides with a tick, the pre-increment count is captured.
- Undefined: lap_req is ignored; lap_value=0 and lap_valid=0 constantly. Ports remain for interface stability.

Decomposition:
Shared package bcd_pkg:
- Command opcode constants: CMD_NOP, CMD_START, CMD_STOP, CMD_CLEAR.
- State encoding: ST_IDLE, ST_RUN, ST_HOLD.
- Constant BCD_MAX=4'd9.

Sub-module bcd_digit_cell, instantiated DIGITS times via generate:
- Inputs: clk, rst_n, en, clr, load_zero.
- Outputs: 4-bit digit, carry (digit==9 && en).
- Prescaler, FSM, terminal compare and lap capture stay in bcd_count_ctrl.

Test Plan:
- Reset: rst_n low mid-count at 0x0347 -> count=0, running=0, cmd_ready=1 immediately, without a clock edge.
- Ripple: DIGITS=4, PRESCALE=1, START from 0x0098 -> after 2 ticks count=0x0100; from 0x9999 -> 0x0000.
- Wrap terminal: limit=0x0005, auto_wrap=1, PRESCALE=3 -> count 0..5 then 0; tc_pulse high one cycle every 18 clk.
- Hold terminal: limit=0x0012, auto_wrap=0 -> count stops at 0x0012, running=0, state HOLD; START -> count=0, running=1.
- Collisions: CLEAR on a tick cycle at count=0x0009 -> count=0x0000, no tc_pulse. STOP on a tick at 0x0004 -> count=0x0005, running=0. Back-to-back cmd_valid -> second command accepted 2 cycles after the first.
- BCD_LAP_CAPTURE_EN: lap_req pulse at count=0x0042 -> lap_value=0x0042, lap_valid=1 while counting continues. With the macro undefined -> lap_value stays 0.
